// File: rtl/qpu_exu_evtq.sv
// Timed event queue: tags event write-backs with the current timing point and
// releases each entry when the free-running QPU timer reaches its timestamp.
module qpu_exu_evtq #(
   parameter int unsigned TIME_W  = 32,
   parameter int unsigned EVT_W   = 16,
   parameter int unsigned EVT_NUM = 8,
   parameter int unsigned DEPTH   = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     twbck_i_valid,
   output logic                     twbck_i_ready,
   input  logic [TIME_W-1:0]        twbck_i_data,
   input  logic                     ewbck_i_valid,
   output logic                     ewbck_i_ready,
   input  logic [EVT_W-1:0]         ewbck_i_data,
   input  logic [EVT_NUM-1:0]       ewbck_i_oprand,
   input  logic                     run_i,
   input  logic                     clr_i,
   output logic                     evt_o_valid,
   output logic [EVT_W-1:0]         evt_o_data,
   output logic [EVT_NUM-1:0]       evt_o_oprand,
   output logic [TIME_W-1:0]        evt_o_time,
   output logic                     late_o,
   output logic [TIME_W-1:0]        tcnt_o,
   output logic                     empty_o,
   output logic                     full_o,
   output logic [$clog2(DEPTH):0]   cnt_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [TIME_W-1:0]  time_q [DEPTH];
   logic [EVT_W-1:0]   data_q [DEPTH];
   logic [EVT_NUM-1:0] opr_q  [DEPTH];

   logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [TIME_W-1:0]  tcnt_q, tcnt_d;
   logic [TIME_W-1:0]  tpoint_q, tpoint_d;
   logic               late_q, late_d;
   logic               evt_valid_q;
   logic [EVT_W-1:0]   evt_data_q;
   logic [EVT_NUM-1:0] evt_opr_q;
   logic [TIME_W-1:0]  evt_time_q;

   logic               tw_hs, ew_hs, push, pop, due;
   logic [TIME_W-1:0]  push_time, head_dt;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == CW'(DEPTH));

   // rst gates ewbck readiness so it stays low until reset is released
   assign twbck_i_ready = ~clr_i;
   assign ewbck_i_ready = ~full_o & ~clr_i & ~rst;

   assign tw_hs     = twbck_i_valid & twbck_i_ready;
   assign ew_hs     = ewbck_i_valid & ewbck_i_ready;
   assign push      = ew_hs & (|ewbck_i_oprand);
   assign push_time = tw_hs ? twbck_i_data : tpoint_q;

   // Head is due once the timer is within the half-range at or past its timestamp
   assign head_dt = tcnt_q - time_q[rd_ptr_q];
   assign due     = ~head_dt[TIME_W-1];
   assign pop     = ~empty_o & due & ~clr_i;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      tcnt_d   = tcnt_q;
      tpoint_d = tpoint_q;
      late_d   = late_q;
      if (clr_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
         tcnt_d   = '0;
         tpoint_d = '0;
         late_d   = 1'b0;
      end else begin
         if (run_i) tcnt_d = tcnt_q + 1'b1;
         if (tw_hs) tpoint_d = twbck_i_data;
         if (push)  wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
         if (pop && (head_dt != '0)) late_d = 1'b1;
         case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            time_q[i] <= '0;
            data_q[i] <= '0;
            opr_q[i]  <= '0;
         end
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         tcnt_q      <= '0;
         tpoint_q    <= '0;
         late_q      <= 1'b0;
         evt_valid_q <= 1'b0;
         evt_data_q  <= '0;
         evt_opr_q   <= '0;
         evt_time_q  <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         tcnt_q      <= tcnt_d;
         tpoint_q    <= tpoint_d;
         late_q      <= late_d;
         evt_valid_q <= pop;
         if (push) begin
            time_q[wr_ptr_q] <= push_time;
            data_q[wr_ptr_q] <= ewbck_i_data;
            opr_q[wr_ptr_q]  <= ewbck_i_oprand;
         end
         if (pop) begin
            evt_data_q <= data_q[rd_ptr_q];
            evt_opr_q  <= opr_q[rd_ptr_q];
            evt_time_q <= time_q[rd_ptr_q];
         end
      end
   end

   assign evt_o_valid  = evt_valid_q;
   assign evt_o_data   = evt_data_q;
   assign evt_o_oprand = evt_opr_q;
   assign evt_o_time   = evt_time_q;
   assign late_o       = late_q;
   assign tcnt_o       = tcnt_q;
   assign cnt_o        = cnt_q;

endmodule
